// File: rtl/soft_rst_gen_if.sv
// soft_rst_gen_if: command strobe and soft-reset status bundle between register decode and soft_rst_gen
interface soft_rst_gen_if;
   logic        cmd_vld;
   logic [15:0] cmd_data;
   logic        soft_rst;
   logic        armed;
   logic        busy;
   logic        key_err;
   logic        cmd_drop;
   logic [7:0]  soft_rst_cnt;
   modport master (
      output cmd_vld, cmd_data,
      input  soft_rst, armed, busy, key_err, cmd_drop, soft_rst_cnt
   );
   modport slave (
      input  cmd_vld, cmd_data,
      output soft_rst, armed, busy, key_err, cmd_drop, soft_rst_cnt
   );
endinterface

// File: rtl/soft_rst_gen.sv
// soft_rst_gen: two-key unlocked soft reset with guaranteed pulse width and post-release hold-off
module soft_rst_gen #(
   parameter logic [15:0] KEY1        = 16'h5A5A,
   parameter logic [15:0] KEY2        = 16'hA5A5,
   parameter logic [15:0] KEY_TIMEOUT = 16'd1000,
   parameter logic [7:0]  RST_WIDTH   = 8'd32,
   parameter logic [15:0] HOLDOFF     = 16'd1250
) (
   input  logic          clk_125m,
   input  logic          rst_125m,
   soft_rst_gen_if.slave bus
);
   localparam logic [15:0] TIMEOUT_LAST = KEY_TIMEOUT - 16'd1;
   localparam logic [15:0] WIDTH_LAST   = {8'd0, RST_WIDTH} - 16'd1;
   localparam logic [15:0] HOLDOFF_LAST = HOLDOFF - 16'd1;
   typedef enum logic [1:0] {IDLE, ARMED, ASSERT, HOLD} state_t;
   state_t      state, state_n;
   logic [15:0] timer, timer_n;
   logic        key_err_n, cmd_drop_n;
   logic [7:0]  cnt_n;
   // next state, timer and event pulses; busy states swallow commands without disturbing the sequence
   always_comb begin
      state_n    = state;
      key_err_n  = 1'b0;
      cmd_drop_n = 1'b0;
      cnt_n      = bus.soft_rst_cnt;
      case (state)
         IDLE: begin
            if (bus.cmd_vld && bus.cmd_data == KEY1) state_n = ARMED;
            else key_err_n = bus.cmd_vld;
         end
         ARMED: begin
            if (bus.cmd_vld && bus.cmd_data == KEY2) begin
               state_n = ASSERT;
               cnt_n   = bus.soft_rst_cnt == 8'hFF ? bus.soft_rst_cnt : bus.soft_rst_cnt + 8'd1;
            end else if (bus.cmd_vld || timer == TIMEOUT_LAST) begin
               state_n   = IDLE;
               key_err_n = 1'b1;
            end
         end
         ASSERT: begin
            cmd_drop_n = bus.cmd_vld;
            state_n    = timer == WIDTH_LAST ? HOLD : ASSERT;
         end
         default: begin
            cmd_drop_n = bus.cmd_vld;
            state_n    = timer == HOLDOFF_LAST ? IDLE : HOLD;
         end
      endcase
      timer_n = state_n != state || state == IDLE ? 16'd0 : timer + 16'd1;
   end
   // state register with outputs decoded from the next state so they move on the transition edge
   always_ff @(posedge clk_125m) begin
      if (rst_125m) begin
         state            <= IDLE;
         timer            <= 16'd0;
         bus.soft_rst     <= 1'b1;
         bus.armed        <= 1'b0;
         bus.busy         <= 1'b0;
         bus.key_err      <= 1'b0;
         bus.cmd_drop     <= 1'b0;
         bus.soft_rst_cnt <= 8'd0;
      end else begin
         state            <= state_n;
         timer            <= timer_n;
         bus.soft_rst     <= state_n != ASSERT;
         bus.armed        <= state_n == ARMED;
         bus.busy         <= state_n == ASSERT || state_n == HOLD;
         bus.key_err      <= key_err_n;
         bus.cmd_drop     <= cmd_drop_n;
         bus.soft_rst_cnt <= cnt_n;
      end
   end
endmodule

// File: tb/tb_soft_rst_gen.sv
// tb_soft_rst_gen: directed and random checks of soft_rst_gen against a time-window reference model
module tb_soft_rst_gen;
   localparam logic [15:0] KEY1 = 16'h5A5A;
   localparam logic [15:0] KEY2 = 16'hA5A5;
   localparam int TO = 1000;
   localparam int RW = 32;
   localparam int HO = 1250;
   logic clk_125m = 1'b0;
   logic rst_125m = 1'b1;
   soft_rst_gen_if bus ();
   soft_rst_gen_if bus_f ();
   soft_rst_gen dut (.clk_125m(clk_125m), .rst_125m(rst_125m), .bus(bus));
   soft_rst_gen #(.HOLDOFF(16'd4)) dut_f (.clk_125m(clk_125m), .rst_125m(rst_125m), .bus(bus_f));
   always #4 clk_125m = ~clk_125m;
   int checks = 0;
   int errors = 0;
   logic [12:0] outs;
   assign outs = {bus.soft_rst, bus.armed, bus.busy, bus.key_err, bus.cmd_drop, bus.soft_rst_cnt};
   int   c = 0;
   int   arm_at = -1;
   int   fire_at = -100000;
   int   m_cnt = 0;
   logic m_kerr = 1'b0;
   logic m_drop = 1'b0;
   function automatic logic [12:0] model_out();
      logic low, bsy, arm;
      low = c >= fire_at && c < fire_at + RW;
      bsy = c >= fire_at && c < fire_at + RW + HO;
      arm = arm_at >= 0 && c >= arm_at;
      return {!low, arm, bsy, m_kerr, m_drop, m_cnt[7:0]};
   endfunction
   task automatic cycle(input logic v, input logic [15:0] d, input logic r = 1'b0);
      rst_125m = r;
      bus.cmd_vld = v;
      bus.cmd_data = d;
      bus_f.cmd_vld = v;
      bus_f.cmd_data = d;
      @(posedge clk_125m);
      m_kerr = 1'b0;
      m_drop = 1'b0;
      if (r) begin
         arm_at = -1;
         fire_at = -100000;
         m_cnt = 0;
      end else if (c >= fire_at && c < fire_at + RW + HO) m_drop = v;
      else if (arm_at >= 0) begin
         if (v && d == KEY2) begin
            fire_at = c + 1;
            arm_at = -1;
            if (m_cnt < 255) m_cnt++;
         end else if (v || c == arm_at + TO - 1) begin
            m_kerr = 1'b1;
            arm_at = -1;
         end
      end else if (v) begin
         if (d == KEY1) arm_at = c + 1;
         else m_kerr = 1'b1;
      end
      c++;
      @(negedge clk_125m);
   endtask
   task automatic test_reset();
      cycle(1'b1, KEY1, 1'b1);
      cycle(1'b0, 16'h0, 1'b1);
      checks++;
      if (outs !== 13'h1000) begin errors++; $display("FAIL reset_state: got %h expected %h", outs, 13'h1000); end
      checks++;
      if (outs !== model_out()) begin errors++; $display("FAIL reset_model: got %h expected %h", outs, model_out()); end
   endtask
   task automatic test_unlock();
      int na = 0, a_first = -1, nl = 0, l_first = -1, nb = 0, b_first = -1;
      for (int k = 0; k < 1300; k++) begin
         cycle(k == 10 || k == 15, k == 10 ? KEY1 : k == 15 ? KEY2 : 16'h0);
         checks++;
         if (outs !== model_out()) begin errors++; $display("FAIL unlock_model k=%0d: got %h expected %h", k, outs, model_out()); end
         if (bus.armed) begin na++; if (a_first < 0) a_first = k + 1; end
         if (!bus.soft_rst) begin nl++; if (l_first < 0) l_first = k + 1; end
         if (bus.busy) begin nb++; if (b_first < 0) b_first = k + 1; end
      end
      checks++;
      if (na != 5 || a_first != 11) begin errors++; $display("FAIL unlock_armed: got %0d from %0d expected 5 from 11", na, a_first); end
      checks++;
      if (nl != 32 || l_first != 16) begin errors++; $display("FAIL unlock_low: got %0d from %0d expected 32 from 16", nl, l_first); end
      checks++;
      if (nb != 1282 || b_first != 16) begin errors++; $display("FAIL unlock_busy: got %0d from %0d expected 1282 from 16", nb, b_first); end
      checks++;
      if (bus.soft_rst_cnt !== 8'd1 || bus.busy !== 1'b0) begin errors++; $display("FAIL unlock_end: got cnt %0d busy %b expected 1 0", bus.soft_rst_cnt, bus.busy); end
   endtask
   task automatic test_wrong_key();
      int ne = 0, nl = 0;
      logic [7:0] cnt0 = bus.soft_rst_cnt;
      for (int k = 0; k < 5; k++) begin
         cycle(k < 2, k == 0 ? KEY1 : 16'h1234);
         checks++;
         if (outs !== model_out()) begin errors++; $display("FAIL wrong_model k=%0d: got %h expected %h", k, outs, model_out()); end
         ne += int'(bus.key_err);
         nl += int'(!bus.soft_rst);
      end
      checks++;
      if (ne != 1 || nl != 0 || bus.armed !== 1'b0) begin errors++; $display("FAIL wrong_key: got err %0d low %0d armed %b expected 1 0 0", ne, nl, bus.armed); end
      checks++;
      if (bus.soft_rst_cnt !== cnt0) begin errors++; $display("FAIL wrong_cnt: got %0d expected %0d", bus.soft_rst_cnt, cnt0); end
   endtask
   task automatic test_timeout();
      int na = 0, a_last = -1, ne = 0, e_at = -1;
      for (int k = 0; k < 1006; k++) begin
         cycle(k == 0, KEY1);
         checks++;
         if (outs !== model_out()) begin errors++; $display("FAIL timeout_model k=%0d: got %h expected %h", k, outs, model_out()); end
         if (bus.armed) begin na++; a_last = k + 1; end
         if (bus.key_err) begin ne++; e_at = k + 1; end
      end
      checks++;
      if (na != TO) begin errors++; $display("FAIL timeout_armed: got %0d expected %0d", na, TO); end
      checks++;
      if (ne != 1 || e_at != a_last + 1) begin errors++; $display("FAIL timeout_err: got %0d at %0d expected 1 at %0d", ne, e_at, a_last + 1); end
   endtask
   task automatic test_timeout_key2();
      int ne = 0, nl = 0;
      logic [7:0] cnt0 = bus.soft_rst_cnt;
      for (int k = 0; k < 2300; k++) begin
         cycle(k == 0 || k == TO, k == 0 ? KEY1 : KEY2);
         checks++;
         if (outs !== model_out()) begin errors++; $display("FAIL late_key2_model k=%0d: got %h expected %h", k, outs, model_out()); end
         ne += int'(bus.key_err);
         nl += int'(!bus.soft_rst);
      end
      checks++;
      if (ne != 0 || nl != RW || bus.soft_rst_cnt !== cnt0 + 8'd1) begin errors++; $display("FAIL late_key2: got err %0d low %0d cnt %0d expected 0 32 %0d", ne, nl, bus.soft_rst_cnt, cnt0 + 8'd1); end
   endtask
   task automatic test_back_to_back();
      int nd = 0, nl = 0;
      logic [7:0] cnt0 = bus.soft_rst_cnt;
      for (int k = 0; k < 1290; k++) begin
         cycle(k == 0 || k == 1 || k == 5 || k == 6 || k == 100, k == 1 || k == 6 ? KEY2 : KEY1);
         checks++;
         if (outs !== model_out()) begin errors++; $display("FAIL busy_model k=%0d: got %h expected %h", k, outs, model_out()); end
         nd += int'(bus.cmd_drop);
         nl += int'(!bus.soft_rst);
      end
      checks++;
      if (nd != 3 || nl != RW || bus.soft_rst_cnt !== cnt0 + 8'd1) begin errors++; $display("FAIL busy_writes: got drop %0d low %0d cnt %0d expected 3 32 %0d", nd, nl, bus.soft_rst_cnt, cnt0 + 8'd1); end
   endtask
   task automatic test_reset_mid_pulse();
      for (int k = 0; k < 12; k++) cycle(k < 2, k == 0 ? KEY1 : KEY2, k == 11);
      checks++;
      if (outs !== 13'h1000) begin errors++; $display("FAIL mid_reset: got %h expected %h", outs, 13'h1000); end
      for (int k = 0; k < 4; k++) begin
         cycle(1'b0, 16'h0);
         checks++;
         if (outs !== model_out()) begin errors++; $display("FAIL mid_reset_model k=%0d: got %h expected %h", k, outs, model_out()); end
      end
   endtask
   task automatic test_random();
      for (int k = 0; k < 5000; k++) begin
         int sel = $urandom_range(3);
         cycle($urandom_range(1) == 1, sel == 0 ? KEY1 : sel == 1 ? KEY2 : 16'($urandom));
         checks++;
         if (outs !== model_out()) begin errors++; $display("FAIL random_model k=%0d: got %h expected %h", k, outs, model_out()); end
      end
   endtask
   task automatic test_saturation();
      cycle(1'b0, 16'h0, 1'b1);
      for (int i = 1; i <= 257; i++) begin
         int nl = 0;
         cycle(1'b1, KEY1);
         cycle(1'b1, KEY2);
         nl += int'(!bus_f.soft_rst);
         for (int j = 0; j < 40; j++) begin
            cycle(1'b0, 16'h0);
            nl += int'(!bus_f.soft_rst);
         end
         checks++;
         if (nl != RW || int'(bus_f.soft_rst_cnt) != (i < 255 ? i : 255)) begin errors++; $display("FAIL saturation i=%0d: got low %0d cnt %0d expected 32 %0d", i, nl, bus_f.soft_rst_cnt, i < 255 ? i : 255); end
      end
   endtask
   initial begin
      bus.cmd_vld = 1'b0;
      bus.cmd_data = 16'h0;
      bus_f.cmd_vld = 1'b0;
      bus_f.cmd_data = 16'h0;
      @(negedge clk_125m);
      test_reset();
      test_unlock();
      test_wrong_key();
      test_timeout();
      test_timeout_key2();
      test_back_to_back();
      test_reset_mid_pulse();
      test_random();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
